// File: rtl/cacheline_adaptor_pkg.sv
// Shared constants and state type for the 256-bit line to 4x64-bit burst adaptor.
// The cache datapath imports LINE_W/OFFSET_W from here as well.
package cacheline_adaptor_pkg;

    localparam int BEATS    = 4;
    localparam int BEAT_W   = 64;
    localparam int LINE_W   = BEATS * BEAT_W;
    localparam int OFFSET_W = 5;
    localparam int ADDR_W   = 32;
    localparam int CNT_W    = 2;

    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((1 << OFFSET_W) - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_e;

    function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
        return addr & LINE_MASK;
    endfunction

endpackage

// File: rtl/cacheline_adaptor_if.sv
// Cache-side line handshake plus memory-side burst bus for the cacheline adaptor.
// slave: the adaptor's view; master: the surrounding cache/memory environment.
interface cacheline_adaptor_if;
    import cacheline_adaptor_pkg::*;

    logic [LINE_W-1:0] line_i;
    logic [LINE_W-1:0] line_o;
    logic [ADDR_W-1:0] address_i;
    logic              read_i;
    logic              write_i;
    logic              resp_o;

    logic [BEAT_W-1:0] burst_i;
    logic [BEAT_W-1:0] burst_o;
    logic [ADDR_W-1:0] address_o;
    logic              read_o;
    logic              write_o;
    logic              resp_i;

    modport slave (
        input  line_i, address_i, read_i, write_i, burst_i, resp_i,
        output line_o, resp_o, burst_o, address_o, read_o, write_o
    );

    modport master (
        output line_i, address_i, read_i, write_i, burst_i, resp_i,
        input  line_o, resp_o, burst_o, address_o, read_o, write_o
    );

endinterface

// File: rtl/cacheline_adaptor.sv
// Splits one 256-bit cache line transfer into a 4-beat 64-bit memory burst and
// answers the cache with a single-cycle resp_o once the burst completes.
//
// state | meaning
// IDLE  | waiting for a line request; write wins over read
// RD    | read burst in flight, beats assembled into line_o by cnt
// WR    | write burst in flight, burst_o presents buffered beat cnt
// DONE  | resp_o high for one cycle; requests and strobes ignored
module cacheline_adaptor
    import cacheline_adaptor_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    cacheline_adaptor_if.slave  bus
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [LINE_W-1:0] rd_line_q, rd_line_d;
    logic [LINE_W-1:0] wr_line_q, wr_line_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              read_q, read_d;
    logic              write_q, write_d;
    logic              resp_q, resp_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_line_d = rd_line_q;
        wr_line_d = wr_line_q;
        addr_d    = addr_q;

        case (state_q)
            IDLE: begin
                if (bus.write_i) begin
                    state_d   = WR;
                    wr_line_d = bus.line_i;
                    addr_d    = line_align(bus.address_i);
                    cnt_d     = '0;
                end else if (bus.read_i) begin
                    state_d = RD;
                    addr_d  = line_align(bus.address_i);
                    cnt_d   = '0;
                end
            end
            RD: begin
                if (bus.resp_i) begin
                    rd_line_d[cnt_q*BEAT_W +: BEAT_W] = bus.burst_i;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BEAT) state_d = DONE;
                end
            end
            WR: begin
                if (bus.resp_i) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BEAT) state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Moore outputs are registered from the next state so they align with it.
        read_d  = (state_d == RD);
        write_d = (state_d == WR);
        resp_d  = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rd_line_q <= '0;
            wr_line_q <= '0;
            addr_q    <= '0;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            resp_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_line_q <= rd_line_d;
            wr_line_q <= wr_line_d;
            addr_q    <= addr_d;
            read_q    <= read_d;
            write_q   <= write_d;
            resp_q    <= resp_d;
        end
    end

    assign bus.line_o    = rd_line_q;
    assign bus.burst_o   = wr_line_q[cnt_q*BEAT_W +: BEAT_W];
    assign bus.address_o = addr_q;
    assign bus.read_o    = read_q;
    assign bus.write_o   = write_q;
    assign bus.resp_o    = resp_q;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Self-checking bench for cacheline_adaptor: directed scenarios plus randomized
// transactions checked cycle by cycle against a transaction-level line model.
module tb_cacheline_adaptor;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cacheline_adaptor_if bus();

    cacheline_adaptor dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [255:0] model_line;
    logic [31:0]  model_addr;
    bit           resp_pat_q[$];
    logic [63:0]  beat_q[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one line transaction; every cycle is compared against the model.
    task automatic do_line_txn(input bit is_wr, input bit is_rd, input logic [31:0] addr,
                               input logic [255:0] line, input int stall_pct, input int exp_edges);
        int beats = 0;
        int edges;
        bit r;
        logic [63:0] b;
        bus.write_i   = is_wr;
        bus.read_i    = is_rd;
        bus.address_i = addr;
        bus.line_i    = line;
        bus.resp_i    = 1'b0;
        model_addr    = {addr[31:5], 5'b0};
        step();
        edges = 1;
        while (beats < 4 && edges < 64) begin
            checks++;
            if (bus.read_o !== !is_wr) begin errors++; $display("FAIL read_o busy: got %b want %b", bus.read_o, !is_wr); end
            checks++;
            if (bus.write_o !== is_wr) begin errors++; $display("FAIL write_o busy: got %b want %b", bus.write_o, is_wr); end
            checks++;
            if (bus.resp_o !== 1'b0) begin errors++; $display("FAIL resp_o busy: got %b want 0", bus.resp_o); end
            checks++;
            if (bus.address_o !== model_addr) begin errors++; $display("FAIL address_o: got %h want %h", bus.address_o, model_addr); end
            checks++;
            if (bus.line_o !== model_line) begin errors++; $display("FAIL line_o busy: got %h want %h", bus.line_o, model_line); end
            if (is_wr) begin
                checks++;
                if (bus.burst_o !== line[64*beats +: 64]) begin
                    errors++; $display("FAIL burst_o beat %0d: got %h want %h", beats, bus.burst_o, line[64*beats +: 64]);
                end
            end
            r = (resp_pat_q.size() > 0) ? resp_pat_q.pop_front() : ($urandom_range(99) >= stall_pct);
            b = (beat_q.size() > 0) ? beat_q.pop_front() : {$urandom, $urandom};
            bus.resp_i  = r;
            bus.burst_i = b;
            if (r) begin
                if (!is_wr) model_line[64*beats +: 64] = b;
                beats++;
            end
            step();
            edges++;
        end
        checks++;
        if (beats < 4) begin errors++; $display("FAIL burst timeout: beats %0d want 4", beats); end
        // DONE cycle: requests still held and a stray strobe must be ignored.
        bus.resp_i = 1'b1;
        checks++;
        if (bus.resp_o !== 1'b1) begin errors++; $display("FAIL resp_o done: got %b want 1", bus.resp_o); end
        checks++;
        if (bus.read_o !== 1'b0 || bus.write_o !== 1'b0) begin
            errors++; $display("FAIL req_o done: got rd %b wr %b want 0 0", bus.read_o, bus.write_o);
        end
        checks++;
        if (bus.line_o !== model_line) begin errors++; $display("FAIL line_o done: got %h want %h", bus.line_o, model_line); end
        if (exp_edges >= 0) begin
            checks++;
            if (edges !== exp_edges) begin errors++; $display("FAIL latency: got %0d edges want %0d", edges, exp_edges); end
        end
        step();
        bus.read_i  = 1'b0;
        bus.write_i = 1'b0;
        bus.resp_i  = 1'b1;
        checks++;
        if (bus.resp_o !== 1'b0) begin errors++; $display("FAIL resp_o after done: got %b want 0", bus.resp_o); end
        checks++;
        if (bus.read_o !== 1'b0 || bus.write_o !== 1'b0) begin
            errors++; $display("FAIL re-accept: got rd %b wr %b want 0 0", bus.read_o, bus.write_o);
        end
        step();
        bus.resp_i = 1'b0;
        checks++;
        if (bus.resp_o !== 1'b0 || bus.read_o !== 1'b0 || bus.write_o !== 1'b0) begin
            errors++; $display("FAIL idle stray: got resp %b rd %b wr %b want 0 0 0", bus.resp_o, bus.read_o, bus.write_o);
        end
        checks++;
        if (bus.line_o !== model_line) begin errors++; $display("FAIL line_o idle: got %h want %h", bus.line_o, model_line); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        model_line = '0;
        model_addr = '0;
        checks++;
        if (bus.line_o !== 256'd0) begin errors++; $display("FAIL reset line_o: got %h want 0", bus.line_o); end
        checks++;
        if (bus.address_o !== 32'd0) begin errors++; $display("FAIL reset address_o: got %h want 0", bus.address_o); end
        checks++;
        if (bus.burst_o !== 64'd0) begin errors++; $display("FAIL reset burst_o: got %h want 0", bus.burst_o); end
        checks++;
        if (bus.read_o !== 1'b0 || bus.write_o !== 1'b0 || bus.resp_o !== 1'b0) begin
            errors++; $display("FAIL reset strobes: got rd %b wr %b resp %b want 0 0 0", bus.read_o, bus.write_o, bus.resp_o);
        end
    endtask

    task automatic test_read_directed();
        beat_q = {64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                  64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
        resp_pat_q = {1'b1, 1'b1, 1'b1, 1'b1};
        do_line_txn(1'b0, 1'b1, 32'h0000_1234, '0, 0, 5);
        checks++;
        if (bus.line_o !== {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                            64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}) begin
            errors++; $display("FAIL read directed line: got %h", bus.line_o);
        end
        checks++;
        if (bus.address_o !== 32'h0000_1220) begin
            errors++; $display("FAIL read directed addr: got %h want 00001220", bus.address_o);
        end
    endtask

    task automatic test_write_stalls();
        logic [255:0] line;
        line = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        resp_pat_q = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        do_line_txn(1'b1, 1'b0, $urandom, line, 0, 8);
    endtask

    task automatic test_simultaneous();
        logic [255:0] line;
        line = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        do_line_txn(1'b1, 1'b1, $urandom, line, 30, -1);
    endtask

    task automatic test_reset_mid_burst();
        bus.read_i    = 1'b1;
        bus.address_i = $urandom;
        step();
        for (int i = 0; i < 2; i++) begin
            bus.resp_i  = 1'b1;
            bus.burst_i = {$urandom, $urandom};
            step();
        end
        rst = 1'b1;
        bus.resp_i = 1'b0;
        step();
        rst = 1'b0;
        bus.read_i = 1'b0;
        model_line = '0;
        model_addr = '0;
        checks++;
        if (bus.read_o !== 1'b0 || bus.resp_o !== 1'b0) begin
            errors++; $display("FAIL mid reset strobes: got rd %b resp %b want 0 0", bus.read_o, bus.resp_o);
        end
        checks++;
        if (bus.line_o !== 256'd0 || bus.address_o !== 32'd0 || bus.burst_o !== 64'd0) begin
            errors++; $display("FAIL mid reset data: line %h addr %h burst %h want 0", bus.line_o, bus.address_o, bus.burst_o);
        end
        step();
        checks++;
        if (bus.resp_o !== 1'b0 || bus.read_o !== 1'b0) begin
            errors++; $display("FAIL aborted resp: got resp %b rd %b want 0 0", bus.resp_o, bus.read_o);
        end
        resp_pat_q = {1'b1, 1'b1, 1'b1, 1'b1};
        do_line_txn(1'b0, 1'b1, $urandom, '0, 0, 5);
    endtask

    task automatic test_back_to_back();
        do_line_txn(1'b0, 1'b1, $urandom, '0, 0, 5);
        do_line_txn(1'b0, 1'b1, $urandom, '0, 40, -1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 25; n++) begin
            bit wr;
            logic [255:0] line;
            wr = $urandom_range(1);
            line = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            do_line_txn(wr, !wr || ($urandom_range(1) == 1), $urandom, line, $urandom_range(60), -1);
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.line_i    = '0;
        bus.address_i = '0;
        bus.read_i    = 1'b0;
        bus.write_i   = 1'b0;
        bus.burst_i   = '0;
        bus.resp_i    = 1'b0;
        test_reset();
        test_read_directed();
        test_write_stalls();
        test_simultaneous();
        test_reset_mid_burst();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
